// File: rtl/gcd_multi.sv
// Queued GCD engine: request FIFO feeding a swap/subtract datapath
// that reports the result and the number of steps it took.
module gcd_multi #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = W + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2*W-1:0]           req_msg,
    input  logic                     req_val,
    output logic                     req_rdy,
    output logic [W-1:0]             resp_msg,
    output logic [CNT_W-1:0]         resp_iter,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [2*W-1:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [2*W-1:0]   head;

    logic [W-1:0]     a, b, a_nx, b_nx;
    logic [W-1:0]     res, res_nx;
    logic [CNT_W-1:0] iter, iter_nx, iter_inc;
    logic [CNT_W-1:0] res_iter, res_iter_nx;

    // ready comes from registered occupancy only, so no full-FIFO bypass
    assign req_rdy  = (count != CW'(DEPTH));
    assign push     = req_val && req_rdy;
    assign pop      = (state == IDLE) && (count != '0);
    assign head     = mem[rd_ptr];
    assign iter_inc = (&iter) ? iter : iter + CNT_W'(1);

    assign resp_val   = (state == DONE);
    assign resp_msg   = res;
    assign resp_iter  = res_iter;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_msg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            iter     <= '0;
            res      <= '0;
            res_iter <= '0;
        end else begin
            state    <= state_nx;
            a        <= a_nx;
            b        <= b_nx;
            iter     <= iter_nx;
            res      <= res_nx;
            res_iter <= res_iter_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        a_nx        = a;
        b_nx        = b;
        iter_nx     = iter;
        res_nx      = res;
        res_iter_nx = res_iter;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    a_nx     = head[2*W-1:W];
                    b_nx     = head[W-1:0];
                    iter_nx  = '0;
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (a < b) begin
                    a_nx    = b;
                    b_nx    = a;
                    iter_nx = iter_inc;
                end else if (b != '0) begin
                    a_nx    = a - b;
                    iter_nx = iter_inc;
                end else begin
                    res_nx      = a;
                    res_iter_nx = iter;
                    state_nx    = DONE;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_multi.sv
// Bench for gcd_multi: directed and random requests checked against
// a Euclid-division model of the expected result and step count.
module tb_gcd_multi;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int LIMIT = 70000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2*W-1:0] req_msg;
    logic          req_val;
    logic          req_rdy;
    logic [W-1:0]  resp_msg;
    logic [W:0]    resp_iter;
    logic          resp_val;
    logic          resp_rdy;
    logic          busy;
    logic [2:0]    fifo_count;

    logic          d1_req_rdy;
    logic [W-1:0]  d1_resp_msg;
    logic [7:0]    d1_resp_iter;
    logic          d1_resp_val;
    logic          d1_busy;
    logic [2:0]    d1_fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

    int unsigned qa[$];
    int unsigned qb[$];
    int unsigned px, py, cx, cy;
    int          lat;

    always #5 clk = ~clk;

    gcd_multi #(.W(W), .DEPTH(DEPTH), .CNT_W(W + 1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_msg    (req_msg),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .resp_msg   (resp_msg),
        .resp_iter  (resp_iter),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    gcd_multi #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_msg    (req_msg),
        .req_val    (req_val),
        .req_rdy    (d1_req_rdy),
        .resp_msg   (d1_resp_msg),
        .resp_iter  (d1_resp_iter),
        .resp_val   (d1_resp_val),
        .resp_rdy   (resp_rdy),
        .busy       (d1_busy),
        .fifo_count (d1_fifo_count)
    );

    // each Euclid division a = q*b + r costs q subtractions plus one swap
    function automatic void model(input int unsigned a, input int unsigned b,
                                  input int cw, output int unsigned g,
                                  output longint unsigned it);
        longint unsigned n = 0;
        longint unsigned cap;
        int unsigned t;
        while (b != 0) begin
            n += a / b + 1;
            t = a % b;
            a = b;
            b = t;
        end
        cap = (64'd1 << cw) - 1;
        g  = a;
        it = (n > cap) ? cap : n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int unsigned a, input int unsigned b);
        int k = 0;
        req_msg = {a[15:0], b[15:0]};
        req_val = 1'b1;
        while (!req_rdy && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (!req_rdy) chk("send_stall", req_rdy, 1);
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic wait_val(input string tag);
        int k = 0;
        while (!resp_val && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (!resp_val) chk({tag, "_timeout"}, resp_val, 1);
    endtask

    task automatic recv(input int unsigned a, input int unsigned b,
                        input string tag);
        int unsigned g, g8;
        longint unsigned it, it8;
        model(a, b, W + 1, g, it);
        model(a, b, 8, g8, it8);
        resp_rdy = 1'b1;
        wait_val(tag);
        if (resp_val) begin
            chk({tag, "_msg"}, resp_msg, g);
            chk({tag, "_iter"}, resp_iter, it);
            chk({tag, "_val8"}, d1_resp_val, 1);
            chk({tag, "_msg8"}, d1_resp_msg, g8);
            chk({tag, "_iter8"}, d1_resp_iter, it8);
            @(negedge clk);
            chk({tag, "_drop"}, resp_val, 0);
        end
        resp_rdy = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        req_msg  = '0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_val", resp_val, 0);
        chk("rst_msg", resp_msg, 0);
        chk("rst_iter", resp_iter, 0);
        chk("rst_rdy", req_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic request and its latency counted from the push
        resp_rdy = 1'b1;
        send(27, 15);
        lat = 0;
        while (!resp_val && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("basic_latency", lat, 11);
        recv(27, 15, "basic");

        recv_zero: begin
            send(0, 0);
            recv(0, 0, "zero_00");
            send(42, 0);
            recv(42, 0, "zero_a0");
            send(0, 7);
            recv(0, 7, "zero_0b");
        end

        // fill the FIFO while the consumer stalls
        resp_rdy = 1'b0;
        send(12, 8);
        send(9, 6);
        send(35, 14);
        send(17, 5);
        send(100, 75);
        req_msg = {16'd21, 16'd14};
        req_val = 1'b1;
        chk("full_count", fifo_count, 4);
        chk("full_rdy", req_rdy, 0);
        wait_val("full");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_val", resp_val, 1);
            chk("stall_msg", resp_msg, 4);
            chk("stall_rdy", req_rdy, 0);
        end
        recv(12, 8, "bp0");
        chk("bp_still_full", fifo_count, 4);
        @(negedge clk);
        chk("bp_pop_no_bypass", fifo_count, 3);
        @(negedge clk);
        chk("bp_refill", fifo_count, 4);
        req_val = 1'b0;
        recv(9, 6, "bp1");
        recv(35, 14, "bp2");
        recv(17, 5, "bp3");
        recv(100, 75, "bp4");
        recv(21, 14, "bp5");
        repeat (2) @(negedge clk);
        chk("bp_idle_busy", busy, 0);

        // simultaneous push and pop with three entries queued
        send(20, 5);
        send(18, 12);
        send(7, 3);
        send(44, 11);
        wait_val("pp");
        recv(20, 5, "pp0");
        chk("pp_count_before", fifo_count, 3);
        req_msg = {16'd30, 16'd18};
        req_val = 1'b1;
        chk("pp_rdy", req_rdy, 1);
        @(negedge clk);
        req_val = 1'b0;
        chk("pp_count_after", fifo_count, 3);
        recv(18, 12, "pp1");
        recv(7, 3, "pp2");
        recv(44, 11, "pp3");
        recv(30, 18, "pp4");

        // reset in the middle of a long calculation
        send(60000, 7);
        send(5, 3);
        send(6, 4);
        send(9, 3);
        @(negedge clk);
        chk("mid_count", fifo_count, 3);
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_val", resp_val, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_rdy", req_rdy, 1);
        chk("arst_busy", busy, 0);
        chk("arst_busy8", d1_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_count", fifo_count, 0);
        send(27, 15);
        recv(27, 15, "post_rst");

        // random traffic with a queued scoreboard
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    px = $urandom_range(0, 255);
                    py = $urandom_range(0, 255);
                    if ($urandom_range(0, 7) == 0) px = 0;
                    if ($urandom_range(0, 7) == 0) py = 0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(px, py);
                    qa.push_back(px);
                    qb.push_back(py);
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    int k = 0;
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    while (qa.size() == 0 && k < LIMIT) begin
                        @(negedge clk);
                        k++;
                    end
                    if (qa.size() != 0) begin
                        cx = qa.pop_front();
                        cy = qb.pop_front();
                        recv(cx, cy, "rand");
                    end else begin
                        chk("rand_queue", qa.size(), 1);
                    end
                end
            end
        join

        // worst case and counter saturation on the narrow instance
        send(1000, 1);
        recv(1000, 1, "sat1000");
        send(65535, 1);
        recv(65535, 1, "worst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
